// File: rtl/morse_pkg.sv
// morse_pkg -- shared types and constants for the Morse character sequencer.
//   state_t        : sequencer FSM states
//   SPACE_ADDR_DEF : default ROM address of the ASCII space entry
//   SYM_W / CNT_W  : width of the collected element pattern and its count
//   MAX_ELEMS_DEF  : default maximum elements per character
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOK_C = 3'd1,
      WR_C   = 3'd2,
      LOOK_S = 3'd3,
      WR_S   = 3'd4
   } state_t;

   localparam logic [7:0] SPACE_ADDR_DEF = 8'hE0;
   localparam int         SYM_W          = 5;
   localparam int         CNT_W          = 3;
   localparam int         MAX_ELEMS_DEF  = 5;

endpackage

// File: rtl/morse_symbol_collector.sv
// morse_symbol_collector -- gathers dot/dash pulses into a shift register.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   dot, dash         : single-cycle element pulses (both high = ignored)
//   clear             : synchronous clear when the sequencer consumes a character
//   symbol[4:0]       : elements so far, newest in bit 0, 1 = dash
//   symbol_count[2:0] : number of elements collected
module morse_symbol_collector
   import morse_pkg::*;
#(
   parameter int MAX_ELEMS = MAX_ELEMS_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dot,
   input  logic             dash,
   input  logic             clear,
   output logic [SYM_W-1:0] symbol,
   output logic [CNT_W-1:0] symbol_count
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ELEMS);

   logic elem;
   assign elem = dot ^ dash;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         symbol       <= '0;
         symbol_count <= '0;
      end else if (clear) begin
         // an element arriving on the clear cycle starts the next character
         if (elem) begin
            symbol       <= {{(SYM_W-1){1'b0}}, dash};
            symbol_count <= CNT_W'(1);
         end else begin
            symbol       <= '0;
            symbol_count <= '0;
         end
      end else if (elem && (symbol_count < MAX_CNT)) begin
         symbol       <= {symbol[SYM_W-2:0], dash};
         symbol_count <= symbol_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer -- turns collected Morse elements into ROM lookups and FIFO
// writes of the decoded character (and a trailing space on a word gap).
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   dot, dash         : element pulses from the decoder
//   lg, wg            : letter-gap / word-gap pulses (both high = word gap)
//   fifo_full         : FIFO full flag, drops the write in progress
//   rom_data[7:0]     : synchronous ROM output (one cycle after rom_addr)
//   rom_addr[7:0]     : registered ROM address {count, pattern} or SPACE_ADDR
//   fifo_din[7:0]     : FIFO write data (rom_data passed through)
//   fifo_wr_en        : FIFO write strobe
//   symbol, symbol_count : in-progress character for the display
//   busy              : FSM not in IDLE
//   overflow          : one-cycle pulse when a character or space is dropped
//   drop_count[7:0]   : saturating overflow counter, only with
//                       MORSE_SEQ_DROP_COUNT_EN defined
module morse_sequencer
   import morse_pkg::*;
#(
   parameter logic [7:0] SPACE_ADDR = SPACE_ADDR_DEF,
   parameter int         MAX_ELEMS  = MAX_ELEMS_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dot,
   input  logic             dash,
   input  logic             lg,
   input  logic             wg,
   input  logic             fifo_full,
   input  logic [7:0]       rom_data,
   output logic [7:0]       rom_addr,
   output logic [7:0]       fifo_din,
   output logic             fifo_wr_en,
   output logic [SYM_W-1:0] symbol,
   output logic [CNT_W-1:0] symbol_count,
   output logic             busy,
   output logic             overflow
`ifdef MORSE_SEQ_DROP_COUNT_EN
   ,
   output logic [7:0]       drop_count
`endif
);

   state_t     state, state_nxt;
   logic [7:0] rom_addr_nxt;
   logic       space_pend, space_pend_nxt;
   logic       clear;
   logic       wr_slot;

   morse_symbol_collector #(
      .MAX_ELEMS (MAX_ELEMS)
   ) u_collector (
      .clk          (clk),
      .reset_n      (reset_n),
      .dot          (dot),
      .dash         (dash),
      .clear        (clear),
      .symbol       (symbol),
      .symbol_count (symbol_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rom_addr   <= 8'h00;
         space_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         rom_addr   <= rom_addr_nxt;
         space_pend <= space_pend_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      rom_addr_nxt   = rom_addr;
      space_pend_nxt = space_pend;
      clear          = 1'b0;
      wr_slot        = 1'b0;
      case (state)
         IDLE: begin
            // wg dominates lg when both arrive together
            if (wg) begin
               if (symbol_count != '0) begin
                  rom_addr_nxt   = {symbol_count, symbol};
                  clear          = 1'b1;
                  space_pend_nxt = 1'b1;
                  state_nxt      = LOOK_C;
               end else begin
                  rom_addr_nxt   = SPACE_ADDR;
                  space_pend_nxt = 1'b0;
                  state_nxt      = LOOK_S;
               end
            end else if (lg && (symbol_count != '0)) begin
               rom_addr_nxt   = {symbol_count, symbol};
               clear          = 1'b1;
               space_pend_nxt = 1'b0;
               state_nxt      = LOOK_C;
            end
         end
         LOOK_C: state_nxt = WR_C;
         WR_C: begin
            wr_slot = 1'b1;
            if (space_pend) begin
               rom_addr_nxt = SPACE_ADDR;
               state_nxt    = LOOK_S;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOOK_S: state_nxt = WR_S;
         WR_S: begin
            wr_slot        = 1'b1;
            space_pend_nxt = 1'b0;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign fifo_din   = rom_data;
   assign fifo_wr_en = wr_slot & ~fifo_full;
   // gaps while busy are lost, as is a write blocked by a full FIFO
   assign overflow   = (busy & (lg | wg)) | (wr_slot & fifo_full);

`ifdef MORSE_SEQ_DROP_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         drop_count <= 8'h00;
      else if (overflow && (drop_count != 8'hFF))
         drop_count <= drop_count + 8'h01;
   end
`endif

endmodule
